// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, forwarding-select encoding and default widths.
package pipe_pkg;

  localparam int unsigned DwDefault = 32;
  localparam int unsigned RwDefault = 5;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result over MEM/WB result over register value.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned RW = RwDefault
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_val,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] fwd_val
);

  fwd_sel_e sel;

  // $zero is never a forwarding target
  always_comb begin
    sel = FWD_REG;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == src)) begin
      sel = FWD_EXM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXM: fwd_val = exm_result;
      FWD_WB:  fwd_val = wb_result;
      default: fwd_val = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional perf counters (bubble_cnt, flush_cnt) enabled by defining IDEX_PERF_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned RW = RwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold_in,
  input  logic          flush_in,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [3:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_result,
  output logic          load_use_stall,
  output logic [DW-1:0] alu_i0,
  output logic [DW-1:0] alu_i1,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   flush_cnt,
`endif
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [3:0]    alu_op;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_t;

  ex_t ex_q, ex_d;
  logic [DW-1:0] fwd_a, fwd_b;

  always_comb begin
    load_use_stall = 1'b0;
    if (!flush_in && ex_q.valid && ex_q.mem_read && id_valid && (ex_q.rd != '0) &&
        ((ex_q.rd == id_rs) || (ex_q.rd == id_rt))) begin
      load_use_stall = 1'b1;
    end
  end

  // hold wins over flush; a flush seen under hold is dropped and re-asserted by the branch unit
  always_comb begin
    ex_d = ex_q;
    if (!hold_in) begin
      if (flush_in || load_use_stall) begin
        ex_d = '0;
      end else begin
        ex_d.valid      = id_valid;
        ex_d.rs_val     = id_rs_val;
        ex_d.rt_val     = id_rt_val;
        ex_d.imm        = id_imm;
        ex_d.rs         = id_rs;
        ex_d.rt         = id_rt;
        ex_d.rd         = id_rd;
        ex_d.alu_op     = id_alu_op;
        ex_d.alu_src    = id_alu_src;
        ex_d.reg_write  = id_reg_write;
        ex_d.mem_read   = id_mem_read;
        ex_d.mem_write  = id_mem_write;
        ex_d.mem_to_reg = id_mem_to_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
    .src          (ex_q.rs),
    .reg_val      (ex_q.rs_val),
    .exm_reg_write(exm_reg_write),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .fwd_val      (fwd_a)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
    .src          (ex_q.rt),
    .reg_val      (ex_q.rt_val),
    .exm_reg_write(exm_reg_write),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .fwd_val      (fwd_b)
  );

  // Invalid slot presents AND 0,0 to the ALU with all side effects off
  always_comb begin
    alu_i0        = ex_q.valid ? fwd_a : '0;
    alu_i1        = ex_q.valid ? (ex_q.alu_src ? ex_q.imm : fwd_b) : '0;
    alu_op        = ex_q.valid ? ex_q.alu_op : AluAnd;
    ex_store_data = ex_q.valid ? fwd_b : '0;
    ex_rd         = ex_q.rd;
    ex_valid      = ex_q.valid;
    ex_reg_write  = ex_q.valid & ex_q.reg_write;
    ex_mem_read   = ex_q.valid & ex_q.mem_read;
    ex_mem_write  = ex_q.valid & ex_q.mem_write;
    ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;
  end

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (!hold_in) begin
      if (flush_in) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end else if (load_use_stall) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold_in, flush_in, id_valid;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_result;
  logic        load_use_stall;
  logic [31:0] alu_i0, alu_i1, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference view of the instruction sitting in EX
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv, imm;
    logic [3:0]  op;
    logic        src, rw, mr, mw, mtr;
  } ex_t;

  ex_t m;
  int unsigned m_bubbles, m_flushes;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .hold_in(hold_in), .flush_in(flush_in), .id_valid(id_valid),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
`ifdef IDEX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regval);
    if (exm_reg_write && exm_rd != 0 && exm_rd == src) return exm_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return wb_result;
    return regval;
  endfunction

  function automatic logic ref_stall();
    return !flush_in && m.v && m.mr && id_valid && m.rd != 0 && (m.rd == id_rs || m.rd == id_rt);
  endfunction

  task automatic clear_inputs();
    hold_in = 0; flush_in = 0; id_valid = 0;
    id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_alu_op = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle
  task automatic tick();
    ex_t nxt;
    nxt = m;
    if (!hold_in) begin
      if (flush_in) begin
        nxt = '0; m_flushes++;
      end else if (ref_stall()) begin
        nxt = '0; m_bubbles++;
      end else begin
        nxt = '{v: id_valid, rs: id_rs, rt: id_rt, rd: id_rd, rsv: id_rs_val, rtv: id_rt_val,
                imm: id_imm, op: id_alu_op, src: id_alu_src, rw: id_reg_write,
                mr: id_mem_read, mw: id_mem_write, mtr: id_mem_to_reg};
      end
    end
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsv, input logic [31:0] rtv, input logic [3:0] op,
                        input logic mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_val = rsv; id_rt_val = rtv;
    id_alu_op = op; id_alu_src = 0; id_imm = 32'h0000_0040; id_reg_write = 1;
    id_mem_read = mr; id_mem_to_reg = mr; id_mem_write = 0;
  endtask

  task automatic test_reset();
    set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, AluAdd, 1'b1);
    tick();
    set_id(5'd3, 5'd2, 5'd4, 32'h33, 32'h44, AluSub, 1'b0);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({ex_valid, alu_i0, alu_i1, alu_op, ex_store_data, ex_reg_write, ex_mem_read,
         ex_mem_write, ex_mem_to_reg, ex_rd} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%b i0=%h i1=%h op=%h sd=%h rd=%h, want all 0",
               ex_valid, alu_i0, alu_i1, alu_op, ex_store_data, ex_rd);
    end
    n_checks++;
    if (load_use_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_stall: got %b want 0", load_use_stall);
    end
    @(negedge clk);
    rst_n = 1;
    m = '0; m_bubbles = 0; m_flushes = 0;
    clear_inputs();
  endtask

  task automatic test_capture();
    set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, AluAdd, 1'b0);
    tick();
    id_valid = 0;
    #1;
    n_checks++;
    if (alu_i0 !== 32'd5 || alu_i1 !== 32'd7 || alu_op !== AluAdd || ex_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL capture: got i0=%0d i1=%0d op=%b v=%b want 5 7 0010 1",
               alu_i0, alu_i1, alu_op, ex_valid);
    end
  endtask

  task automatic test_forward_priority();
    set_id(5'd3, 5'd9, 5'd8, 32'h99, 32'h1, AluOr, 1'b0);
    tick();
    id_valid = 0;
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'h10;
    wb_reg_write = 1;  wb_rd = 3;  wb_result = 32'h20;
    #1;
    n_checks++;
    if (alu_i0 !== 32'h10) begin
      n_errors++; $display("FAIL fwd_exm_wins: got %h want 00000010", alu_i0);
    end
    exm_reg_write = 0;
    #1;
    n_checks++;
    if (alu_i0 !== 32'h20) begin
      n_errors++; $display("FAIL fwd_wb: got %h want 00000020", alu_i0);
    end
    exm_reg_write = 1; exm_rd = 0; wb_rd = 0;
    set_id(5'd0, 5'd0, 5'd8, 32'h55, 32'h66, AluOr, 1'b0);
    @(negedge clk);
    tick();
    id_valid = 0;
    #1;
    n_checks++;
    if (alu_i0 !== 32'h55 || ex_store_data !== 32'h66) begin
      n_errors++;
      $display("FAIL fwd_zero_reg: got i0=%h sd=%h want 00000055 00000066", alu_i0, ex_store_data);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, AluAdd, 1'b1);
    tick();
    set_id(5'd4, 5'd5, 5'd6, 32'hDEAD, 32'h3, AluAdd, 1'b0);
    #1;
    n_checks++;
    if (load_use_stall !== 1'b1) begin
      n_errors++; $display("FAIL load_use_detect: got %b want 1", load_use_stall);
    end
    tick();
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || load_use_stall !== 1'b0 || alu_op !== 4'b0000) begin
      n_errors++;
      $display("FAIL load_use_bubble: got v=%b stall=%b op=%b want 0 0 0000",
               ex_valid, load_use_stall, alu_op);
    end
    tick();
    wb_reg_write = 1; wb_rd = 4; wb_result = 32'h1234;
    #1;
    n_checks++;
    if (ex_valid !== 1'b1 || alu_i0 !== 32'h1234 || alu_i1 !== 32'h3 || ex_rd !== 5'd6) begin
      n_errors++;
      $display("FAIL load_use_fwd: got v=%b i0=%h i1=%h rd=%0d want 1 00001234 00000003 6",
               ex_valid, alu_i0, alu_i1, ex_rd);
    end
  endtask

  task automatic test_hold_flush();
    wb_reg_write = 0;
    hold_in = 1; flush_in = 1;
    set_id(5'd6, 5'd7, 5'd9, 32'h1, 32'h2, AluSlt, 1'b0);
    #1;
    n_checks++;
    if (load_use_stall !== 1'b0) begin
      n_errors++; $display("FAIL flush_masks_stall: got %b want 0", load_use_stall);
    end
    tick();
    #1;
    n_checks++;
    if (ex_valid !== 1'b1 || alu_op !== AluAdd || ex_rd !== 5'd6 || ex_reg_write !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_over_flush: got v=%b op=%b rd=%0d rw=%b want 1 0010 6 1",
               ex_valid, alu_op, ex_rd, ex_reg_write);
    end
    hold_in = 0;
    tick();
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || alu_op !== 4'b0000 || ex_reg_write !== 1'b0) begin
      n_errors++;
      $display("FAIL flush: got v=%b op=%b rw=%b want 0 0000 0", ex_valid, alu_op, ex_reg_write);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int bad = 0;
    logic [31:0] fa, fb;
    logic [31:0] e_i0, e_i1, e_sd;
    logic [3:0]  e_op;
    logic [4:0]  e_ctl;
    for (int i = 0; i < 400; i++) begin
      hold_in = ($urandom_range(0, 7) == 0);
      flush_in = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_rs_val = $urandom; id_rt_val = $urandom; id_imm = $urandom;
      id_alu_op = 4'($urandom); id_alu_src = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
      #1;
      fa = ref_fwd(m.rs, m.rsv);
      fb = ref_fwd(m.rt, m.rtv);
      e_i0 = m.v ? fa : 0;
      e_i1 = m.v ? (m.src ? m.imm : fb) : 0;
      e_sd = m.v ? fb : 0;
      e_op = m.v ? m.op : 0;
      e_ctl = m.v ? {1'b1, m.rw, m.mr, m.mw, m.mtr} : 5'b0;
      n_checks++;
      if (load_use_stall !== ref_stall()) begin
        n_errors++; bad++;
        if (bad < 10) $display("FAIL rand_stall[%0d]: got %b want %b", i, load_use_stall,
                               ref_stall());
      end
      n_checks++;
      if ({alu_i0, alu_i1, ex_store_data, alu_op} !== {e_i0, e_i1, e_sd, e_op} ||
          {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== e_ctl ||
          (m.v && ex_rd !== m.rd)) begin
        n_errors++; bad++;
        if (bad < 10)
          $display("FAIL rand_outputs[%0d]: got i0=%h i1=%h sd=%h op=%h ctl=%b rd=%0d want %h %h %h %h %b %0d",
                   i, alu_i0, alu_i1, ex_store_data, alu_op,
                   {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, ex_rd,
                   e_i0, e_i1, e_sd, e_op, e_ctl, m.rd);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

`ifdef IDEX_PERF_CNT_EN
  task automatic make_bubble(input bit with_hold);
    set_id(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, AluAdd, 1'b1);
    tick();
    set_id(5'd7, 5'd3, 5'd8, 32'h4, 32'h5, AluAdd, 1'b0);
    if (with_hold) begin
      hold_in = 1;
      tick();
      hold_in = 0;
    end
    tick();
    tick();
    clear_inputs();
  endtask

  task automatic test_perf();
    logic [31:0] b0, f0;
    b0 = bubble_cnt; f0 = flush_cnt;
    make_bubble(1'b1);
    make_bubble(1'b0);
    make_bubble(1'b0);
    set_id(5'd1, 5'd1, 5'd1, 32'h0, 32'h0, AluOr, 1'b0);
    flush_in = 1;
    tick();
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (bubble_cnt - b0 !== 32'd3 || flush_cnt - f0 !== 32'd2) begin
      n_errors++;
      $display("FAIL perf_delta: got bubbles=%0d flushes=%0d want 3 2",
               bubble_cnt - b0, flush_cnt - f0);
    end
    n_checks++;
    if (bubble_cnt !== 32'(m_bubbles) || flush_cnt !== 32'(m_flushes)) begin
      n_errors++;
      $display("FAIL perf_total: got bubbles=%0d flushes=%0d want %0d %0d",
               bubble_cnt, flush_cnt, m_bubbles, m_flushes);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst_n = 0;
    m = '0; m_bubbles = 0; m_flushes = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_capture();
    test_forward_priority();
    test_load_use();
    test_hold_flush();
    test_random();
`ifdef IDEX_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
